// File: rtl/divider_unit.sv
// divider_unit
//   Iterative 32-bit integer divider for a pipelined core. It produces one
//   quotient bit per cycle with a restoring shift-subtract loop. Signed ops
//   divide operand magnitudes and fix the signs when the result is written.
//   Divide-by-zero and signed overflow bypass the loop and finish in one
//   cycle.
//
//   State table:
//     state | meaning
//     IDLE  | waiting for start_i; busy_o=0
//     RUN   | 32 shift-subtract steps, then one finalize cycle that writes result
//     DONE  | one cycle: done_o=1, result_o valid, then back to IDLE
//
//   Ports:
//     clk       in   clock; all state updates on the rising edge
//     reset     in   asynchronous active-low reset
//     start_i   in   request pulse; op_i/A_i/B_i are sampled when accepted in IDLE
//     op_i      in   [1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU
//     A_i       in   [WIDTH-1:0] dividend
//     B_i       in   [WIDTH-1:0] divisor
//     flush_i   in   abort; forces IDLE at the next edge and wins over start_i
//     busy_o    out  registered; high in RUN and DONE (pipeline stall)
//     done_o    out  one-cycle pulse while result_o carries a new value
//     result_o  out  [WIDTH-1:0] quotient or remainder; held until next DONE
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0]       ITER_LAST = 6'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic             op_rem_q, op_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;

  // combinational temporaries
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   a_ext, b_ext;
  logic [WIDTH:0]   a_abs, b_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   div_ext;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_rem_q  <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_rem_q  <= op_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_rem_d  = op_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    busy_d    = busy_q;

    // Magnitudes are formed in WIDTH+1 bits so that the most negative
    // dividend maps to its true unsigned magnitude.
    signed_op = ~op_i[0];
    a_neg     = signed_op & A_i[WIDTH-1];
    b_neg     = signed_op & B_i[WIDTH-1];
    a_ext     = {a_neg, A_i};
    b_ext     = {b_neg, B_i};
    a_abs     = a_neg ? ((WIDTH+1)'(0) - a_ext) : a_ext;
    b_abs     = b_neg ? ((WIDTH+1)'(0) - b_ext) : b_ext;

    rem_shift = {rem_q, quo_q[WIDTH-1]};
    div_ext   = {1'b0, div_q};
    quo_fix   = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
    rem_fix   = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;

    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          op_rem_d  = op_i[1];
          quo_d     = WIDTH'(a_abs);
          div_d     = WIDTH'(b_abs);
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          busy_d    = 1'b1;
          if (B_i == '0) begin
            // Remainder for divide-by-zero is the raw dividend, not its magnitude.
            result_d = op_i[1] ? A_i : '1;
            state_d  = DONE;
          end else if (signed_op && (A_i == MIN_NEG) && (B_i == '1)) begin
            result_d = op_i[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (cnt_q != ITER_LAST) begin
          if (rem_shift >= div_ext) begin
            rem_d = WIDTH'(rem_shift - div_ext);
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = WIDTH'(rem_shift);
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          // Finalize cycle: sign-correct and publish the selected result.
          result_d = op_rem_q ? rem_fix : quo_fix;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Flush aborts from any state and must not publish a result.
    if (flush_i) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      result_d = result_q;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_divider_unit.sv
// Directed testbench for divider_unit. Inputs change at negedge;
// outputs are sampled at negedge, mid-cycle between rising edges.
module tb_divider_unit;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  divider_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .A_i      (A_i),
    .B_i      (B_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at the next rising edge (edge k). lat = i means done_o was
  // seen in the cycle after edge k+i; -1 means no done within the budget.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic [31:0] res, output logic busy_ok);
    @(negedge clk);
    start_i = 1'b1; op_i = op; A_i = a; B_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1; res = 'x; busy_ok = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (!busy_o) busy_ok = 1'b0;
      if (done_o) begin
        lat = i; res = result_o;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
    int lat; logic [31:0] res; logic busy_ok;
    run_op(op, a, b, lat, res, busy_ok);
    total_cnt++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (res !== exp_res) $display("FAIL %s result: got %h expected %h", name, res, exp_res);
    else pass_cnt++;
    total_cnt++;
    if (busy_ok !== 1'b1) $display("FAIL %s busy: got dropped expected held", name);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL %s after_done: got busy=%b done=%b expected 0 0", name, busy_o, done_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0; A_i = '0; B_i = '0;
    #3;
    total_cnt++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0)
      $display("FAIL reset_state: got busy=%b done=%b res=%h expected 0 0 0", busy_o, done_o, result_o);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_unsigned();
    check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    check_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    check_op("divu_big",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
    check_op("remu_big",   OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
  endtask

  task automatic test_signed();
    check_op("div_m7_2",    OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    check_op("rem_m7_2",    OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    check_op("div_7_m2",    OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    check_op("rem_7_m2",    OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    check_op("div_m100_m7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
    check_op("rem_m100_m7", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33);
  endtask

  task automatic test_div_zero();
    check_op("div_by0",  OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    check_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    check_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    check_op("rem_by0",  OP_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
  endtask

  task automatic test_overflow();
    check_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    check_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    logic        seen_done;
    logic        res_moved;
    int lat; logic [31:0] res; logic busy_ok;
    prev = result_o;
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; A_i = 32'd1000; B_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    res_moved = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (result_o !== prev) res_moved = 1'b1;
    end
    total_cnt++;
    if (res_moved !== 1'b0) $display("FAIL run_result_hold: got changed expected %h", prev);
    else pass_cnt++;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== prev)
      $display("FAIL flush_state: got busy=%b done=%b res=%h expected 0 0 %h", busy_o, done_o, result_o, prev);
    else pass_cnt++;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen_done = 1'b1;
    end
    total_cnt++;
    if (seen_done !== 1'b0) $display("FAIL flush_no_done: got done pulse expected none");
    else pass_cnt++;
    check_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    // start and flush together in IDLE: flush wins
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; A_i = 32'd9; B_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL flush_wins: got busy=%b expected 0", busy_o);
    else pass_cnt++;
    run_op(OP_DIVU, 32'd9, 32'd3, lat, res, busy_ok);
    total_cnt++;
    if (res !== 32'd3 || lat !== 33) $display("FAIL post_flush_wins: got res=%h lat=%0d expected 3 33", res, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; A_i = 32'd77; B_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0)
      $display("FAIL reset_mid: got busy=%b done=%b res=%h expected 0 0 0", busy_o, done_o, result_o);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen_done = 1'b1;
    end
    total_cnt++;
    if (seen_done !== 1'b0) $display("FAIL reset_no_done: got done pulse expected none");
    else pass_cnt++;
    // First edge after release: start accepted immediately.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_op("first_after_reset", OP_DIVU, 32'd77, 32'd5, 32'd15, 33);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; A_i = 32'd100; B_i = 32'd7;
    @(posedge clk); #1;
    // hold start with different operands while busy
    op_i = OP_DIV; A_i = 32'd50; B_i = 32'd5;
    lat = -1; res = 'x;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (done_o) begin
        lat = i; res = result_o;
        break;
      end
    end
    start_i = 1'b0;
    total_cnt++;
    if (res !== 32'd14 || lat !== 33)
      $display("FAIL start_ignored: got res=%h lat=%0d expected 0000000e 33", res, lat);
    else pass_cnt++;
    check_op("b2b_next", OP_REMU, 32'd50, 32'd6, 32'd2, 33);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
